// File: rtl/register_bank_32_if.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_32_if
// Description : Write-back and issue bus for register_bank_32.
//               master : pipeline side, drives write-back and issue strobes,
//                        receives busy scoreboard and write counter.
//               slave  : register bank side.
//               Signals:
//                 wr_en_i / wr_addr_i / wr_data_i : write-back port
//                 issue_en_i / issue_rd_i         : issue destination port
//                 busy_o                          : pending-write scoreboard
//                 wr_count_o                      : saturating write counter
// Revision    : 1.0 - initial release
// ============================================================================
interface register_bank_32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                       wr_en_i;
    logic [ADDR_WIDTH-1:0]      wr_addr_i;
    logic [DATA_WIDTH-1:0]      wr_data_i;
    logic                       issue_en_i;
    logic [ADDR_WIDTH-1:0]      issue_rd_i;
    logic [(2**ADDR_WIDTH)-1:0] busy_o;
    logic [15:0]                wr_count_o;

    modport master (
        output wr_en_i,
        output wr_addr_i,
        output wr_data_i,
        output issue_en_i,
        output issue_rd_i,
        input  busy_o,
        input  wr_count_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_data_i,
        input  issue_en_i,
        input  issue_rd_i,
        output busy_o,
        output wr_count_o
    );
endinterface
`default_nettype wire

// File: rtl/register_bank_32.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_32
// Description : 32 x 32-bit architectural register bank feeding the register
//               file read mux. Register 0 reads as zero and ignores writes.
//               Includes the write-address decoder, a saturating 16-bit count
//               of accepted writes and a busy scoreboard marking registers
//               with an in-flight write (set on issue, cleared on write-back,
//               issue wins when both hit the same register on one edge).
// Ports       : clk_i      - rising-edge clock
//               rst_n_i    - asynchronous active-low reset
//               bus        - register_bank_32_if.slave (write-back, issue,
//                            busy scoreboard, write counter)
//               reg0_o..reg31_o - register contents, to mux in0..in31
// Options     : REGBANK_WRITE_BYPASS_EN - when defined, regN_o presents
//               wr_data_i combinationally while that register is being
//               written (0-cycle read-after-write). Storage and busy_o are
//               unchanged by the option.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_n_i,
    register_bank_32_if.slave          bus,
    output logic [DATA_WIDTH-1:0]      reg0_o,
    output logic [DATA_WIDTH-1:0]      reg1_o,
    output logic [DATA_WIDTH-1:0]      reg2_o,
    output logic [DATA_WIDTH-1:0]      reg3_o,
    output logic [DATA_WIDTH-1:0]      reg4_o,
    output logic [DATA_WIDTH-1:0]      reg5_o,
    output logic [DATA_WIDTH-1:0]      reg6_o,
    output logic [DATA_WIDTH-1:0]      reg7_o,
    output logic [DATA_WIDTH-1:0]      reg8_o,
    output logic [DATA_WIDTH-1:0]      reg9_o,
    output logic [DATA_WIDTH-1:0]      reg10_o,
    output logic [DATA_WIDTH-1:0]      reg11_o,
    output logic [DATA_WIDTH-1:0]      reg12_o,
    output logic [DATA_WIDTH-1:0]      reg13_o,
    output logic [DATA_WIDTH-1:0]      reg14_o,
    output logic [DATA_WIDTH-1:0]      reg15_o,
    output logic [DATA_WIDTH-1:0]      reg16_o,
    output logic [DATA_WIDTH-1:0]      reg17_o,
    output logic [DATA_WIDTH-1:0]      reg18_o,
    output logic [DATA_WIDTH-1:0]      reg19_o,
    output logic [DATA_WIDTH-1:0]      reg20_o,
    output logic [DATA_WIDTH-1:0]      reg21_o,
    output logic [DATA_WIDTH-1:0]      reg22_o,
    output logic [DATA_WIDTH-1:0]      reg23_o,
    output logic [DATA_WIDTH-1:0]      reg24_o,
    output logic [DATA_WIDTH-1:0]      reg25_o,
    output logic [DATA_WIDTH-1:0]      reg26_o,
    output logic [DATA_WIDTH-1:0]      reg27_o,
    output logic [DATA_WIDTH-1:0]      reg28_o,
    output logic [DATA_WIDTH-1:0]      reg29_o,
    output logic [DATA_WIDTH-1:0]      reg30_o,
    output logic [DATA_WIDTH-1:0]      reg31_o
);

    localparam int              c_NUM_REGS    = 2**ADDR_WIDTH;
    localparam int              c_COUNT_WIDTH = 16;
    localparam [c_COUNT_WIDTH-1:0] c_COUNT_MAX = {c_COUNT_WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    // Storage. Register 0 has no flop at all; its output is tied to zero.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    r_regs [1:c_NUM_REGS-1];
    logic [c_NUM_REGS-1:1]    r_busy;
    logic [c_COUNT_WIDTH-1:0] r_wr_count;

    // One-hot write and issue selects, bit 0 intentionally absent so that
    // address 0 can never enable anything.
    logic [c_NUM_REGS-1:1]    w_wr_dec;
    logic [c_NUM_REGS-1:1]    w_iss_dec;
    logic                     w_wr_accept;

    logic [DATA_WIDTH-1:0]    w_reg_view [0:c_NUM_REGS-1];

    // ------------------------------------------------------------------------
    // Write / issue address decode
    // ------------------------------------------------------------------------
    assign w_wr_accept = bus.wr_en_i && (bus.wr_addr_i != '0);

    always_comb begin
        w_wr_dec  = '0;
        w_iss_dec = '0;
        for (int i = 1; i < c_NUM_REGS; i++) begin
            w_wr_dec[i]  = bus.wr_en_i    && (bus.wr_addr_i  == ADDR_WIDTH'(i));
            w_iss_dec[i] = bus.issue_en_i && (bus.issue_rd_i == ADDR_WIDTH'(i));
        end
    end

    // ------------------------------------------------------------------------
    // Register storage: exactly one register loads per accepted write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                if (w_wr_dec[i]) begin
                    r_regs[i] <= bus.wr_data_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Busy scoreboard. Issue is checked first: a new issue to the register
    // being written back belongs to a younger instruction, so the register
    // must stay busy even though the older result is stored.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                if (w_iss_dec[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_dec[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.busy_o = {r_busy, 1'b0};

    // ------------------------------------------------------------------------
    // Accepted-write counter, holds at all-ones instead of wrapping.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_count <= '0;
        end else if (w_wr_accept && (r_wr_count != c_COUNT_MAX)) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    assign bus.wr_count_o = r_wr_count;

    // ------------------------------------------------------------------------
    // Read view presented to the mux
    // ------------------------------------------------------------------------
    assign w_reg_view[0] = '0;

    generate
        for (genvar g = 1; g < c_NUM_REGS; g++) begin : g_view
`ifdef REGBANK_WRITE_BYPASS_EN
            // Forward write-back data in the same cycle it is being written.
            assign w_reg_view[g] = w_wr_dec[g] ? bus.wr_data_i : r_regs[g];
`else
            assign w_reg_view[g] = r_regs[g];
`endif
        end
    endgenerate

    assign reg0_o  = w_reg_view[0];
    assign reg1_o  = w_reg_view[1];
    assign reg2_o  = w_reg_view[2];
    assign reg3_o  = w_reg_view[3];
    assign reg4_o  = w_reg_view[4];
    assign reg5_o  = w_reg_view[5];
    assign reg6_o  = w_reg_view[6];
    assign reg7_o  = w_reg_view[7];
    assign reg8_o  = w_reg_view[8];
    assign reg9_o  = w_reg_view[9];
    assign reg10_o = w_reg_view[10];
    assign reg11_o = w_reg_view[11];
    assign reg12_o = w_reg_view[12];
    assign reg13_o = w_reg_view[13];
    assign reg14_o = w_reg_view[14];
    assign reg15_o = w_reg_view[15];
    assign reg16_o = w_reg_view[16];
    assign reg17_o = w_reg_view[17];
    assign reg18_o = w_reg_view[18];
    assign reg19_o = w_reg_view[19];
    assign reg20_o = w_reg_view[20];
    assign reg21_o = w_reg_view[21];
    assign reg22_o = w_reg_view[22];
    assign reg23_o = w_reg_view[23];
    assign reg24_o = w_reg_view[24];
    assign reg25_o = w_reg_view[25];
    assign reg26_o = w_reg_view[26];
    assign reg27_o = w_reg_view[27];
    assign reg28_o = w_reg_view[28];
    assign reg29_o = w_reg_view[29];
    assign reg30_o = w_reg_view[30];
    assign reg31_o = w_reg_view[31];

endmodule
`default_nettype wire

// File: tb/tb_register_bank_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank_32
// Description : Scoreboard testbench for register_bank_32. Stimulus pushes
//               expected values tagged with the cycle they must appear in;
//               a monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank_32;

    localparam int c_KIND_REG   = 0;
    localparam int c_KIND_BUSY  = 1;
    localparam int c_KIND_COUNT = 2;

    typedef struct {
        int          due;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] regs [32];
    int          cyc;
    int          checks;
    int          failures;
    chk_t        q[$];

    register_bank_32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_bank_32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave),
        .reg0_o  (regs[0]),  .reg1_o  (regs[1]),  .reg2_o  (regs[2]),  .reg3_o  (regs[3]),
        .reg4_o  (regs[4]),  .reg5_o  (regs[5]),  .reg6_o  (regs[6]),  .reg7_o  (regs[7]),
        .reg8_o  (regs[8]),  .reg9_o  (regs[9]),  .reg10_o (regs[10]), .reg11_o (regs[11]),
        .reg12_o (regs[12]), .reg13_o (regs[13]), .reg14_o (regs[14]), .reg15_o (regs[15]),
        .reg16_o (regs[16]), .reg17_o (regs[17]), .reg18_o (regs[18]), .reg19_o (regs[19]),
        .reg20_o (regs[20]), .reg21_o (regs[21]), .reg22_o (regs[22]), .reg23_o (regs[23]),
        .reg24_o (regs[24]), .reg25_o (regs[25]), .reg26_o (regs[26]), .reg27_o (regs[27]),
        .reg28_o (regs[28]), .reg29_o (regs[29]), .reg30_o (regs[30]), .reg31_o (regs[31])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int due, input int kind, input int idx, input logic [31:0] v);
        chk_t c;
        c.due  = due;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = v;
        q.push_back(c);
    endtask

    function automatic string chk_name(input chk_t c);
        if (c.kind == c_KIND_REG)       return $sformatf("reg%0d_o", c.idx);
        else if (c.kind == c_KIND_BUSY) return "busy_o";
        else                            return "wr_count_o";
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk_t        c;
            logic [31:0] act;
            c = q.pop_front();
            checks++;
            if (c.kind == c_KIND_REG)       act = regs[c.idx];
            else if (c.kind == c_KIND_BUSY) act = bus.busy_o;
            else                            act = {16'h0, bus.wr_count_o};
            if (c.due != cyc) begin
                failures++;
                $display("FAIL %s cycle %0d missed (now %0d)", chk_name(c), c.due, cyc);
            end else if (act !== c.exp) begin
                failures++;
                $display("FAIL %s cycle %0d actual=%h required=%h", chk_name(c), cyc, act, c.exp);
            end
        end
    end

    initial begin
        int c;
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        bus.wr_en_i    = 1'b0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.issue_en_i = 1'b0;
        bus.issue_rd_i = '0;

        // Reset state
        step();
        expect_at(cyc, c_KIND_REG,   5, 32'h0);
        expect_at(cyc, c_KIND_BUSY,  0, 32'h0);
        expect_at(cyc, c_KIND_COUNT, 0, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Write all 32 addresses, one per cycle (address 0 is ignored)
        for (int n = 0; n < 32; n++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_addr_i = 5'(n);
            bus.wr_data_i = 32'hA5A5_0000 + 32'(n);
            step();
        end
        bus.wr_en_i = 1'b0;
        for (int n = 0; n < 32; n++)
            expect_at(cyc, c_KIND_REG, n, (n == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(n));
        expect_at(cyc, c_KIND_COUNT, 0, 32'd31);
        expect_at(cyc, c_KIND_BUSY,  0, 32'h0);
        step();

        // Scoreboard: issue rd=7 in cycle 1, write reg7 in cycle 4
        c = cyc;
        bus.issue_en_i = 1'b1;
        bus.issue_rd_i = 5'd7;
        expect_at(c,     c_KIND_BUSY, 0, 32'h0);
        expect_at(c + 1, c_KIND_BUSY, 0, 32'h80);
        expect_at(c + 2, c_KIND_BUSY, 0, 32'h80);
        expect_at(c + 3, c_KIND_BUSY, 0, 32'h80);
        expect_at(c + 4, c_KIND_BUSY, 0, 32'h0);
        expect_at(c + 4, c_KIND_REG,  7, 32'h1234);
        expect_at(c + 4, c_KIND_COUNT, 0, 32'd32);
        step();
        bus.issue_en_i = 1'b0;
        step();
        step();
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 5'd7;
        bus.wr_data_i = 32'h1234;
        step();
        bus.wr_en_i = 1'b0;
        step();

        // Same-edge issue and write to reg9: issue wins, data still stored
        c = cyc;
        bus.issue_en_i = 1'b1;
        bus.issue_rd_i = 5'd9;
        bus.wr_en_i    = 1'b1;
        bus.wr_addr_i  = 5'd9;
        bus.wr_data_i  = 32'h55;
        expect_at(c + 1, c_KIND_BUSY,  0, 32'h200);
        expect_at(c + 1, c_KIND_REG,   9, 32'h55);
        expect_at(c + 1, c_KIND_COUNT, 0, 32'd33);
        step();
        // Issue and write to register 0: both ignored
        bus.issue_rd_i = 5'd0;
        bus.wr_addr_i  = 5'd0;
        bus.wr_data_i  = 32'hFFFF_FFFF;
        expect_at(c + 2, c_KIND_BUSY,  0, 32'h200);
        expect_at(c + 2, c_KIND_REG,   0, 32'h0);
        expect_at(c + 2, c_KIND_COUNT, 0, 32'd33);
        step();
        // Independent issue rd=12 and write reg9
        bus.issue_rd_i = 5'd12;
        bus.wr_addr_i  = 5'd9;
        bus.wr_data_i  = 32'h66;
        expect_at(c + 3, c_KIND_BUSY,  0, 32'h1000);
        expect_at(c + 3, c_KIND_REG,   9, 32'h66);
        expect_at(c + 3, c_KIND_COUNT, 0, 32'd34);
        step();
        // Re-issue to busy reg12 keeps it busy
        bus.wr_en_i = 1'b0;
        expect_at(c + 4, c_KIND_BUSY, 0, 32'h1000);
        step();
        // Write-back to reg12 clears it
        bus.issue_en_i = 1'b0;
        bus.wr_en_i    = 1'b1;
        bus.wr_addr_i  = 5'd12;
        bus.wr_data_i  = 32'h12;
        expect_at(c + 5, c_KIND_BUSY,  0, 32'h0);
        expect_at(c + 5, c_KIND_REG,  12, 32'h12);
        expect_at(c + 5, c_KIND_COUNT, 0, 32'd35);
        step();
        bus.wr_en_i = 1'b0;
        step();

        // Write reg3 = CAFE: same-cycle view depends on the bypass option
        c = cyc;
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 5'd3;
        bus.wr_data_i = 32'hCAFE;
`ifdef REGBANK_WRITE_BYPASS_EN
        expect_at(c, c_KIND_REG, 3, 32'hCAFE);
`else
        expect_at(c, c_KIND_REG, 3, 32'hA5A5_0003);
`endif
        expect_at(c,     c_KIND_BUSY,  0, 32'h0);
        expect_at(c + 1, c_KIND_REG,   3, 32'hCAFE);
        expect_at(c + 1, c_KIND_COUNT, 0, 32'd36);
        step();
        bus.wr_en_i = 1'b0;
        step();

        // Load reg5, then assert reset asynchronously mid-cycle with a
        // write and issue pending; all of it must be discarded.
        c = cyc;
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 5'd5;
        bus.wr_data_i = 32'hDEAD_BEEF;
        expect_at(c + 1, c_KIND_REG, 5, 32'hDEAD_BEEF);
        step();
        bus.wr_en_i = 1'b0;
        step();
        rst_n          = 1'b0;
        bus.wr_en_i    = 1'b1;
        bus.wr_data_i  = 32'h1;
        bus.issue_en_i = 1'b1;
        bus.issue_rd_i = 5'd5;
        expect_at(c + 2, c_KIND_REG,   5, 32'h0);
        expect_at(c + 2, c_KIND_BUSY,  0, 32'h0);
        expect_at(c + 2, c_KIND_COUNT, 0, 32'h0);
        step();
        expect_at(c + 3, c_KIND_REG,   5, 32'h0);
        expect_at(c + 3, c_KIND_BUSY,  0, 32'h0);
        expect_at(c + 3, c_KIND_COUNT, 0, 32'h0);
        bus.wr_en_i    = 1'b0;
        bus.issue_en_i = 1'b0;
        rst_n          = 1'b1;
        step();

        // Saturation: 65537 consecutive writes to reg1
        c = cyc;
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 5'd1;
        bus.wr_data_i = 32'h0BAD_F00D;
        expect_at(c,         c_KIND_COUNT, 0, 32'h0);
        expect_at(c + 65534, c_KIND_COUNT, 0, 32'hFFFE);
        expect_at(c + 65535, c_KIND_COUNT, 0, 32'hFFFF);
        expect_at(c + 65536, c_KIND_COUNT, 0, 32'hFFFF);
        expect_at(c + 65537, c_KIND_COUNT, 0, 32'hFFFF);
        repeat (65537) step();
        bus.wr_en_i = 1'b0;
        step();
        expect_at(cyc, c_KIND_COUNT, 0, 32'hFFFF);
        expect_at(cyc, c_KIND_REG,   1, 32'h0BAD_F00D);
        step();

        // Drain with a bounded wait
        for (int k = 0; k < 10 && q.size() > 0; k++) step();
        while (q.size() > 0) begin
            chk_t lc;
            lc = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s cycle %0d never checked (timeout)", chk_name(lc), lc.due);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_bank_32.md
Name: register_bank_32

Overview:
- Storage stage directly upstream of the 32-input register-file read mux.
- Holds 32 x 32-bit architectural registers and exposes all 32 in parallel (reg0_o..reg31_o), which connect to the mux data inputs in0..in31.
- Contains the write-address decoder, hardwired-zero register 0, and a busy scoreboard. The scoreboard tracks registers with an in-flight write so the pipeline can detect read-after-write hazards.

Parameters:
- DATA_WIDTH, 32, width of each register and of the write data.
- ADDR_WIDTH, 5, register address width. Fixed relation: register count = 2**ADDR_WIDTH = 32.

Ports:
- clk_i  input  1  rising-edge clock
- rst_n_i  input  1  asynchronous, active-low reset
- wr_en_i  input  1  write-back strobe
- wr_addr_i  input  5  write-back destination register
- wr_data_i  input  32  write-back data
- issue_en_i  input  1  instruction issued that will write issue_rd_i
- issue_rd_i  input  5  destination register of the issued instruction
- busy_o  output  32  scoreboard; bit N = register N has a pending write
- wr_count_o  output  16  number of accepted writes since reset, saturating
- reg0_o .. reg31_o  output  32 each  current register contents, to mux in0..in31

Behaviour:
- Reset (rst_n_i low, asynchronous, independent of clk_i):
  - all registers = 0, busy_o = 0, wr_count_o = 0.
  - Outputs change immediately on assertion.
  - Release is sampled on the next rising edge.
- Reset mid-operation: any write or issue on the same edge as reset assertion is discarded.
- Write:
  - On a rising edge with wr_en_i=1 and wr_addr_i!=0, register[wr_addr_i] <= wr_data_i.
  - regN_o shows the new value after the edge (1-cycle latency).
- Register 0:
  - reg0_o is constant 0.
  - Writes to address 0 are ignored: no storage change, no busy change, wr_count_o not incremented.
- Write decode: one-hot from wr_addr_i; exactly one register is enabled per write. All other registers hold.
- wr_count_o:
  - Increments by 1 per accepted write (wr_en_i=1, addr!=0).
  - Saturates at 16'hFFFF and does not wrap.
- Scoreboard, per bit N>0, evaluated on each rising edge:
  - set = issue_en_i && issue_rd_i==N
  - clr = wr_en_i && wr_addr_i==N
  - set and clr both true: busy[N] <= 1 (new issue wins over completing older write; data is still written).
  - only set: busy[N] <= 1; re-issue to an already-busy register keeps it 1.
  - only clr: busy[N] <= 0; write to a non-busy register is legal, busy stays 0.
  - neither: hold.
- busy_o[0] is always 0; issue to register 0 is ignored.
- Issue and write to different registers on the same edge are fully independent.
- No combinational path from any input to any output, except as given under Optional Feature.

Optional Feature:
- Macro: REGBANK_WRITE_BYPASS_EN.
- Defined:
  - While wr_en_i=1 and wr_addr_i=N (N!=0), regN_o combinationally presents wr_data_i in the same cycle, so the downstream mux reads write-back data with 0-cycle latency.
  - Storage update is unchanged.
  - reg0_o stays 0.
  - busy_o is unaffected, i.e. not bypassed.
- Undefined: regN_o is driven purely from storage (1-cycle latency, as above).

Test Plan:
- Reset:
  - Stimulus: assert rst_n_i=0 asynchronously between edges after loading reg5=32'hDEADBEEF.
  - Response: reg5_o=0, busy_o=0, wr_count_o=0 immediately, before the next edge.
- Write all:
  - Stimulus: write 32'hA5A5_0000+N to each N=0..31, one per cycle.
  - Response: reg0_o=0; regN_o=32'hA5A5_0000+N for N=1..31; wr_count_o=31.
- Scoreboard:
  - Stimulus: issue rd=7 at cycle 1; write reg7=32'h1234 at cycle 4.
  - Response: busy_o[7]=1 for cycles 2-4; busy_o[7]=0 and reg7_o=32'h1234 from cycle 5.
- Simultaneous events:
  - Stimulus: same edge issue rd=9 and write reg9=32'h55.
  - Response: busy_o[9]=1, reg9_o=32'h55.
  - Stimulus: issue rd=0 alongside.
  - Response: busy_o[0]=0.
- Saturation:
  - Stimulus: force/preload wr_count to 16'hFFFE, do 3 writes to reg1.
  - Response: wr_count_o=16'hFFFF and stays.
- Bypass (REGBANK_WRITE_BYPASS_EN defined):
  - Stimulus: wr_en_i=1, wr_addr_i=3, wr_data_i=32'hCAFE.
  - Response: reg3_o=32'hCAFE in the same cycle.
  - Macro undefined: reg3_o shows 32'hCAFE only after the edge.
